conv_window_feeder: RTL and testbench

Sliding-window front end for the convolution datapath, sitting directly upstream of the convolution operator. It accepts a scalar sample stream with valid/ready and builds `Conv::LEN`-wide windows with stride `STRIDE`. It holds the kernel register and presents a stable `{kernel, window}` pair to the operator's `in_valid`/`in_ready` input. Windows never span a row boundary marked by `s_last`.

---
 rtl/conv_window_feeder_pkg.sv | 32 +++
 rtl/conv_window_feeder_shift_window.sv | 92 +++++++++
 rtl/conv_window_feeder.sv | 89 ++++++++
 tb/tb_conv_window_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : Conv
// Description : Shared element width, window length and vector types for the
//               convolution datapath, plus a window shift helper.
// Revision    : 1.0 - initial release
// ============================================================================
package Conv;

    localparam int WIDTH = 8;
    localparam int LEN   = 4;

    typedef logic [WIDTH-1:0] sample_t;

    // data[0] is the oldest element, data[LEN-1] the newest.
    typedef struct packed {
        sample_t [LEN-1:0] data;
    } data_vector;

    // Drop the oldest element and append a new sample at index LEN-1.
    function automatic data_vector shift_in(input data_vector v, input sample_t s);
        data_vector r;
        r = v;
        for (int i = 0; i < LEN - 1; i++) begin
            r.data[i] = v.data[i + 1];
        end
        r.data[LEN - 1] = s;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_feeder_shift_window.sv
`default_nettype none
// ============================================================================
// Module      : conv_shift_window
// Description : LEN-deep sample shift register with row fill and stride phase
//               tracking. Presents the post-shift window combinationally and
//               raises o_emit when the accepted sample completes a window.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_shift_window
    import Conv::*;
#(
    parameter int STRIDE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_accept,
    input  sample_t    i_sample,
    input  logic       i_last,
    output data_vector o_window,
    output logic       o_emit
);

    localparam int FILL_W  = $clog2(LEN + 1);
    localparam int PHASE_W = $clog2(STRIDE + 1);

    localparam logic [FILL_W-1:0]  c_FILL_FULL = FILL_W'(LEN);
    localparam logic [FILL_W-1:0]  c_FILL_PRE  = FILL_W'(LEN - 1);
    localparam logic [FILL_W-1:0]  c_FILL_ONE  = FILL_W'(1);
    localparam logic [PHASE_W-1:0] c_PHASE_END = PHASE_W'(STRIDE);
    localparam logic [PHASE_W-1:0] c_PHASE_ONE = PHASE_W'(1);

    data_vector          r_shift;
    logic [FILL_W-1:0]   r_fill;
    logic [PHASE_W-1:0]  r_phase;

    data_vector          w_window;
    logic                w_full;
    logic                w_first;
    logic [PHASE_W-1:0]  w_phase_inc;
    logic                w_emit;
    logic [FILL_W-1:0]   w_fill_next;
    logic [PHASE_W-1:0]  w_phase_next;

    assign w_window    = shift_in(r_shift, i_sample);
    assign w_full      = (r_fill == c_FILL_FULL);
    // Reaching LEN from LEN-1 can only happen once per row since the row
    // end clears fill.
    assign w_first     = (r_fill == c_FILL_PRE);
    assign w_phase_inc = r_phase + c_PHASE_ONE;
    assign w_emit      = i_accept && (w_first || (w_full && (w_phase_inc == c_PHASE_END)));

    // Next fill/phase: row end wins over everything, emit restarts the stride.
    always_comb begin
        w_fill_next  = r_fill;
        w_phase_next = r_phase;
        if (i_accept) begin
            if (i_last) begin
                w_fill_next  = '0;
                w_phase_next = '0;
            end else begin
                if (!w_full) begin
                    w_fill_next = r_fill + c_FILL_ONE;
                end
                if (w_emit) begin
                    w_phase_next = '0;
                end else if (w_full) begin
                    w_phase_next = w_phase_inc;
                end
            end
        end
    end

    // Shift register and row counters, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_fill  <= '0;
            r_phase <= '0;
        end else begin
            if (i_accept) begin
                r_shift <= w_window;
            end
            r_fill  <= w_fill_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_window = w_window;
    assign o_emit   = w_emit;

endmodule
`default_nettype wire

// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_feeder
// Description : Sliding-window front end for the convolution operator. Builds
//               LEN-wide windows with stride STRIDE from a sample stream,
//               holds the kernel, and presents a stable {kernel, window} pair.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_feeder
    import Conv::*;
#(
    parameter int STRIDE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  sample_t    s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  data_vector kernel_in,
    input  logic       kernel_load,
    output logic       kernel_ready,
    output data_vector kernel,
    output data_vector data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    logic       r_out_valid;
    logic       r_out_last;
    data_vector r_data;
    data_vector r_kernel;

    logic       w_accept;
    logic       w_emit;
    logic       w_kernel_we;
    data_vector w_window;

    // A pending window blocks new samples unless it is consumed this cycle,
    // so an accepted sample can never overwrite an unconsumed window.
    assign s_ready      = !r_out_valid || out_ready;
    assign kernel_ready = !r_out_valid;
    assign w_accept     = s_valid && s_ready;
    assign w_kernel_we  = kernel_load && kernel_ready;

    conv_shift_window #(
        .STRIDE   (STRIDE)
    ) u_shift_window (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_sample (s_data),
        .i_last   (s_last),
        .o_window (w_window),
        .o_emit   (w_emit)
    );

    // Output window register: loaded on emit, valid cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_data      <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= s_last;
            r_data      <= w_window;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Kernel register: loads only while no window is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kernel <= '0;
        end else if (w_kernel_we) begin
            r_kernel <= kernel_in;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign data      = r_data;
    assign kernel    = r_kernel;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_feeder
// Description : Self-checking bench for conv_window_feeder, stride 1 and 2
//               instances driven with shared directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_feeder;
    import Conv::*;

    logic       clk = 1'b0;
    logic       rst;
    sample_t    s_data;
    logic       s_valid;
    logic       s_last;
    logic       kernel_load;
    logic       out_ready;
    data_vector kernel_in;

    logic       s_ready0, s_ready1, kernel_ready0, kernel_ready1;
    logic       out_valid0, out_valid1, out_last0, out_last1;
    data_vector kernel0, kernel1, data0, data1;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per instance.
    logic       m_ov   [2];
    logic       m_last [2];
    data_vector m_data [2];
    data_vector m_kern [2];
    data_vector m_hist [2];
    int         m_row  [2];
    int         c_str  [2] = '{1, 2};

    always #5 clk = ~clk;

    conv_window_feeder #(.STRIDE(1)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready0), .kernel_in(kernel_in), .kernel_load(kernel_load),
        .kernel_ready(kernel_ready0), .kernel(kernel0), .data(data0),
        .out_valid(out_valid0), .out_last(out_last0), .out_ready(out_ready)
    );

    conv_window_feeder #(.STRIDE(2)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready1), .kernel_in(kernel_in), .kernel_load(kernel_load),
        .kernel_ready(kernel_ready1), .kernel(kernel1), .data(data1),
        .out_valid(out_valid1), .out_last(out_last1), .out_ready(out_ready)
    );

    function automatic data_vector mk(input int a, input int b, input int c, input int e);
        data_vector v;
        v.data[0] = sample_t'(a);
        v.data[1] = sample_t'(b);
        v.data[2] = sample_t'(c);
        v.data[3] = sample_t'(e);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d]   = 1'b0;
            m_last[d] = 1'b0;
            m_data[d] = '0;
            m_kern[d] = '0;
            m_hist[d] = '0;
            m_row[d]  = 0;
        end
    endtask

    // Windows of a row start at sample LEN and then every STRIDE samples.
    task automatic model_step(input int d);
        logic acc;
        logic emit;
        acc  = s_valid && (!m_ov[d] || out_ready);
        emit = 1'b0;
        if (kernel_load && !m_ov[d]) m_kern[d] = kernel_in;
        if (acc) begin
            for (int i = 0; i < LEN - 1; i++) m_hist[d].data[i] = m_hist[d].data[i + 1];
            m_hist[d].data[LEN - 1] = s_data;
            m_row[d]++;
            if (m_row[d] >= LEN && ((m_row[d] - LEN) % c_str[d]) == 0) emit = 1'b1;
        end
        if (emit) begin
            m_ov[d]   = 1'b1;
            m_data[d] = m_hist[d];
            m_last[d] = s_last;
        end else if (out_ready) begin
            m_ov[d] = 1'b0;
        end
        if (acc && s_last) m_row[d] = 0;
    endtask

    task automatic check_all();
        chk("d0 out_valid",    64'(out_valid0),    64'(m_ov[0]));
        chk("d0 out_last",     64'(out_last0),     64'(m_last[0]));
        chk("d0 data",         64'(data0),         64'(m_data[0]));
        chk("d0 kernel",       64'(kernel0),       64'(m_kern[0]));
        chk("d0 s_ready",      64'(s_ready0),      64'(!m_ov[0] || out_ready));
        chk("d0 kernel_ready", 64'(kernel_ready0), 64'(!m_ov[0]));
        chk("d1 out_valid",    64'(out_valid1),    64'(m_ov[1]));
        chk("d1 out_last",     64'(out_last1),     64'(m_last[1]));
        chk("d1 data",         64'(data1),         64'(m_data[1]));
        chk("d1 kernel",       64'(kernel1),       64'(m_kern[1]));
        chk("d1 s_ready",      64'(s_ready1),      64'(!m_ov[1] || out_ready));
        chk("d1 kernel_ready", 64'(kernel_ready1), 64'(!m_ov[1]));
    endtask

    task automatic step(input logic sv, input int sd, input logic sl,
                        input logic kl, input data_vector kin, input logic ordy);
        s_valid     = sv;
        s_data      = sample_t'(sd);
        s_last      = sl;
        kernel_load = kl;
        kernel_in   = kin;
        out_ready   = ordy;
        #1;
        check_all();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int sd, input logic sl);
        step(1'b1, sd, sl, 1'b0, '0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        kernel_load = 1'b0; kernel_in = '0; out_ready = 1'b1;
        model_reset();
        #1;
        check_all();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Stride 1 and 2 over samples 1..8, row closed on 8.
        for (int i = 1; i <= 8; i++) begin
            feed(i, i == 8);
            if (i == 4) begin
                chk("s1 win1", 64'(data0), 64'(mk(1, 2, 3, 4)));
                chk("s2 win1", 64'(data1), 64'(mk(1, 2, 3, 4)));
            end
            if (i == 5) begin
                chk("s1 win2", 64'(data0), 64'(mk(2, 3, 4, 5)));
                chk("s2 no win at 5", 64'(out_valid1), 64'(0));
            end
            if (i == 6) chk("s2 win2", 64'(data1), 64'(mk(3, 4, 5, 6)));
        end
        chk("s2 win3", 64'(data1), 64'(mk(5, 6, 7, 8)));
        chk("s1 last", 64'(out_last0), 64'(1));

        // Short row emits nothing; next full row emits one window with last.
        feed(1, 1'b0); feed(2, 1'b0); feed(3, 1'b1);
        chk("short row", 64'(out_valid0), 64'(0));
        feed(10, 1'b0); feed(11, 1'b0); feed(12, 1'b0); feed(13, 1'b1);
        chk("row win", 64'(data0), 64'(mk(10, 11, 12, 13)));
        chk("row last", 64'(out_last0), 64'(1));
        idle();

        // Backpressure on window {1..4}.
        feed(1, 1'b0); feed(2, 1'b0); feed(3, 1'b0); feed(4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5, 1'b0, 1'b0, '0, 1'b0);
            chk("bp data", 64'(data0), 64'(mk(1, 2, 3, 4)));
            chk("bp s_ready", 64'(s_ready0), 64'(0));
        end
        step(1'b1, 5, 1'b0, 1'b0, '0, 1'b1);
        chk("bp release", 64'(data0), 64'(mk(2, 3, 4, 5)));

        // Kernel load gating.
        step(1'b0, 0, 1'b0, 1'b1, data_vector'(32'hAAAA_AAAA), 1'b0);
        chk("kload blocked", 64'(kernel0), 64'(0));
        idle();
        step(1'b0, 0, 1'b0, 1'b1, data_vector'(32'hAAAA_AAAA), 1'b1);
        chk("kload taken", 64'(kernel0), 64'h0000_0000_AAAA_AAAA);
        feed(0, 1'b1);

        // Reset mid-fill.
        feed(1, 1'b0); feed(2, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        feed(21, 1'b0); feed(22, 1'b0); feed(23, 1'b0);
        chk("rst no early win", 64'(out_valid0), 64'(0));
        feed(24, 1'b0);
        chk("rst win", 64'(data0), 64'(mk(21, 22, 23, 24)));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 data_vector'($urandom), $urandom_range(0, 3) != 0);
        end
        #1;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
